// File: rtl/tri_raster_scan_pkg.sv
// rtl/tri_raster_scan_pkg.sv - shared constants, scan state enum and min/max helpers
package tri_raster_scan_pkg;

    localparam int COORD_W = 9;
    localparam int IDX_X   = 2;
    localparam int IDX_Y   = 1;
    localparam int IDX_Z   = 0;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BBOX,
        ST_ISSUE,
        ST_WAIT,
        ST_ADV
    } scan_state_t;

    function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
        coord_t m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
        coord_t m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

endpackage

// File: rtl/tri_bbox.sv
// rtl/tri_bbox.sv - combinational unsigned bounding box of three vertices
module tri_bbox
    import tri_raster_scan_pkg::*;
(
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic [COORD_W-1:0] x2,
    input  logic [COORD_W-1:0] y2,
    input  logic [COORD_W-1:0] x3,
    input  logic [COORD_W-1:0] y3,
    output logic [COORD_W-1:0] xmin,
    output logic [COORD_W-1:0] xmax,
    output logic [COORD_W-1:0] ymin,
    output logic [COORD_W-1:0] ymax
);

    always_comb begin
        xmin = min3(x1, x2, x3);
        xmax = max3(x1, x2, x3);
        ymin = min3(y1, y2, y3);
        ymax = max3(y1, y2, y3);
    end

endmodule

// File: rtl/tri_raster_scan.sv
// rtl/tri_raster_scan.sv - bounding-box raster scanner feeding a point-in-triangle tester
// Optional screen clipping of the bounding box is enabled by macro SCREEN_CLIP_EN.
module tri_raster_scan
    import tri_raster_scan_pkg::*;
#(
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [COORD_W-1:0] v1 [2:0],
    input  logic [COORD_W-1:0] v2 [2:0],
    input  logic [COORD_W-1:0] v3 [2:0],
    input  logic               tri_valid_in,
    output logic               tri_ready_out,
    output logic [COORD_W-1:0] test_x,
    output logic [COORD_W-1:0] test_y,
    output logic [COORD_W-1:0] test_v1 [2:0],
    output logic [COORD_W-1:0] test_v2 [2:0],
    output logic [COORD_W-1:0] test_v3 [2:0],
    output logic               test_valid,
    input  logic               test_in_tri,
    input  logic               test_done,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               pix_valid,
    output logic               scan_done,
    output logic [16:0]        frag_count
);

`ifdef SCREEN_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    localparam coord_t X_LIM = coord_t'(SCREEN_W - 1);
    localparam coord_t Y_LIM = coord_t'(SCREEN_H - 1);

    scan_state_t state;
    coord_t      x_lo;
    coord_t      x_hi;
    coord_t      y_hi;

    coord_t bb_xmin, bb_xmax, bb_ymin, bb_ymax;
    coord_t lim_xmax, lim_ymax;
    logic   off_screen;

    tri_bbox u_bbox (
        .x1   (test_v1[IDX_X]),
        .y1   (test_v1[IDX_Y]),
        .x2   (test_v2[IDX_X]),
        .y2   (test_v2[IDX_Y]),
        .x3   (test_v3[IDX_X]),
        .y3   (test_v3[IDX_Y]),
        .xmin (bb_xmin),
        .xmax (bb_xmax),
        .ymin (bb_ymin),
        .ymax (bb_ymax)
    );

    // Clamping only touches the upper bounds; a box starting off-screen is dropped whole.
    always_comb begin
        lim_xmax   = bb_xmax;
        lim_ymax   = bb_ymax;
        off_screen = 1'b0;
        if (CLIP_EN) begin
            if (bb_xmax > X_LIM) lim_xmax = X_LIM;
            if (bb_ymax > Y_LIM) lim_ymax = Y_LIM;
            off_screen = (bb_xmin > X_LIM) || (bb_ymin > Y_LIM);
        end
    end

    // test_x/test_y double as the scan cursor, so they are stable for the whole query.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= ST_IDLE;
            tri_ready_out <= 1'b1;
            test_valid    <= 1'b0;
            pix_valid     <= 1'b0;
            scan_done     <= 1'b0;
            frag_count    <= '0;
            test_x        <= '0;
            test_y        <= '0;
            pix_x         <= '0;
            pix_y         <= '0;
            x_lo          <= '0;
            x_hi          <= '0;
            y_hi          <= '0;
            test_v1       <= '{default: '0};
            test_v2       <= '{default: '0};
            test_v3       <= '{default: '0};
        end else begin
            test_valid <= 1'b0;
            pix_valid  <= 1'b0;
            scan_done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tri_valid_in) begin
                        test_v1       <= v1;
                        test_v2       <= v2;
                        test_v3       <= v3;
                        frag_count    <= '0;
                        tri_ready_out <= 1'b0;
                        state         <= ST_BBOX;
                    end
                end
                ST_BBOX: begin
                    if (off_screen) begin
                        scan_done     <= 1'b1;
                        tri_ready_out <= 1'b1;
                        state         <= ST_IDLE;
                    end else begin
                        x_lo       <= bb_xmin;
                        x_hi       <= lim_xmax;
                        y_hi       <= lim_ymax;
                        test_x     <= bb_xmin;
                        test_y     <= bb_ymin;
                        test_valid <= 1'b1;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (test_done) begin
                        if (test_in_tri) begin
                            pix_valid <= 1'b1;
                            pix_x     <= test_x;
                            pix_y     <= test_y;
                            if (frag_count != '1) frag_count <= frag_count + 17'd1;
                        end
                        state <= ST_ADV;
                    end
                end
                ST_ADV: begin
                    if (test_x < x_hi) begin
                        test_x     <= test_x + coord_t'(1);
                        test_valid <= 1'b1;
                        state      <= ST_ISSUE;
                    end else if (test_y < y_hi) begin
                        test_x     <= x_lo;
                        test_y     <= test_y + coord_t'(1);
                        test_valid <= 1'b1;
                        state      <= ST_ISSUE;
                    end else begin
                        scan_done     <= 1'b1;
                        tri_ready_out <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    tri_ready_out <= 1'b1;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tri_raster_scan.sv
// tb/tb_tri_raster_scan.sv - self-checking bench for tri_raster_scan with a behavioural tester model
module tb_tri_raster_scan;

    localparam int W = 320;
    localparam int H = 240;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [8:0]  v1 [2:0];
    logic [8:0]  v2 [2:0];
    logic [8:0]  v3 [2:0];
    logic        tri_valid_in;
    logic        tri_ready_out;
    logic [8:0]  test_x, test_y;
    logic [8:0]  test_v1 [2:0];
    logic [8:0]  test_v2 [2:0];
    logic [8:0]  test_v3 [2:0];
    logic        test_valid;
    logic        test_in_tri;
    logic        test_done;
    logic [8:0]  pix_x, pix_y;
    logic        pix_valid;
    logic        scan_done;
    logic [16:0] frag_count;

    tri_raster_scan #(.SCREEN_W(W), .SCREEN_H(H)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .v1            (v1),
        .v2            (v2),
        .v3            (v3),
        .tri_valid_in  (tri_valid_in),
        .tri_ready_out (tri_ready_out),
        .test_x        (test_x),
        .test_y        (test_y),
        .test_v1       (test_v1),
        .test_v2       (test_v2),
        .test_v3       (test_v3),
        .test_valid    (test_valid),
        .test_in_tri   (test_in_tri),
        .test_done     (test_done),
        .pix_x         (pix_x),
        .pix_y         (pix_y),
        .pix_valid     (pix_valid),
        .scan_done     (scan_done),
        .frag_count    (frag_count)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // observed events
    int q_x[$], q_y[$], q_c[$];
    int p_x[$], p_y[$];
    int sd_cnt = 0;
    int stab_err = 0;
    // expected events
    int e_qx[$], e_qy[$], e_px[$], e_py[$];

    // tester model state
    int         tester_delay = 3;
    int         cnt = 0;
    bit         outstanding = 0;
    bit         abandon = 0;
    int         sx, sy;
    logic [8:0] sv [6];

    function automatic bit in_tri(input int px, input int py, input int x1, input int y1,
                                  input int x2, input int y2, input int x3, input int y3);
        int e1, e2, e3;
        e1 = (x2 - x1) * (py - y1) - (y2 - y1) * (px - x1);
        e2 = (x3 - x2) * (py - y2) - (y3 - y2) * (px - x2);
        e3 = (x1 - x3) * (py - y3) - (y1 - y3) * (px - x3);
        return (e1 >= 0 && e2 >= 0 && e3 >= 0) || (e1 <= 0 && e2 <= 0 && e3 <= 0);
    endfunction

    // Tester: answers each query after tester_delay cycles (0 = random 1..20); also records traffic.
    always @(negedge clk_in) begin
        test_done = 1'b0;
        if (abandon) outstanding = 0;
        if (cnt > 0) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
                test_done   = 1'b1;
                test_in_tri = in_tri(sx, sy, int'(sv[0]), int'(sv[1]), int'(sv[2]),
                                     int'(sv[3]), int'(sv[4]), int'(sv[5]));
                outstanding = 0;
            end
        end
        if (outstanding && !test_valid &&
            (int'(test_x) != sx || int'(test_y) != sy ||
             test_v1[2] !== sv[0] || test_v1[1] !== sv[1] || test_v2[2] !== sv[2] ||
             test_v2[1] !== sv[3] || test_v3[2] !== sv[4] || test_v3[1] !== sv[5]))
            stab_err++;
        if (test_valid) begin
            q_x.push_back(int'(test_x));
            q_y.push_back(int'(test_y));
            q_c.push_back(cyc);
            sx = int'(test_x);
            sy = int'(test_y);
            sv[0] = test_v1[2]; sv[1] = test_v1[1];
            sv[2] = test_v2[2]; sv[3] = test_v2[1];
            sv[4] = test_v3[2]; sv[5] = test_v3[1];
            outstanding = 1;
            cnt = (tester_delay != 0) ? tester_delay : int'($urandom_range(1, 20));
        end
        if (pix_valid) begin
            p_x.push_back(int'(pix_x));
            p_y.push_back(int'(pix_y));
        end
        if (scan_done) sd_cnt++;
    end

    task automatic e_clear();
        e_qx.delete(); e_qy.delete(); e_px.delete(); e_py.delete();
    endtask

    // Reference: raster-scan the (optionally clipped) bounding box, keep inside pixels.
    task automatic model_add(input int ax, input int ay, input int bx, input int by,
                             input int cx, input int cy);
        int xl, xh, yl, yh;
        xl = ax; if (bx < xl) xl = bx; if (cx < xl) xl = cx;
        xh = ax; if (bx > xh) xh = bx; if (cx > xh) xh = cx;
        yl = ay; if (by < yl) yl = by; if (cy < yl) yl = cy;
        yh = ay; if (by > yh) yh = by; if (cy > yh) yh = cy;
`ifdef SCREEN_CLIP_EN
        if (xl > W - 1 || yl > H - 1) return;
        if (xh > W - 1) xh = W - 1;
        if (yh > H - 1) yh = H - 1;
`endif
        for (int y = yl; y <= yh; y++)
            for (int x = xl; x <= xh; x++) begin
                e_qx.push_back(x); e_qy.push_back(y);
                if (in_tri(x, y, ax, ay, bx, by, cx, cy)) begin
                    e_px.push_back(x); e_py.push_back(y);
                end
            end
    endtask

    task automatic start_tri(input int ax, input int ay, input int bx, input int by,
                             input int cx, input int cy, input bit keep, output int acc);
        int n = 0;
        @(negedge clk_in);
        v1[2] = 9'(ax); v1[1] = 9'(ay); v1[0] = 9'($urandom_range(0, 511));
        v2[2] = 9'(bx); v2[1] = 9'(by); v2[0] = 9'($urandom_range(0, 511));
        v3[2] = 9'(cx); v3[1] = 9'(cy); v3[0] = 9'($urandom_range(0, 511));
        tri_valid_in = 1'b1;
        while (!tri_ready_out && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        checks++;
        if (n >= 100) begin
            failures++;
            $display("FAIL accept_timeout got=ready_low exp=ready_high");
        end
        acc = cyc;
        @(negedge clk_in);
        if (!keep) tri_valid_in = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (sd_cnt < target && n < 6000) begin
            @(negedge clk_in);
            n++;
        end
        repeat (3) @(negedge clk_in);
        checks++;
        if (n >= 6000) begin
            failures++;
            $display("FAIL scan_done_timeout got=%0d exp=%0d", sd_cnt, target);
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1; tri_valid_in = 1'b0; test_done = 1'b0; test_in_tri = 1'b0;
        v1 = '{default: '0}; v2 = '{default: '0}; v3 = '{default: '0};
        repeat (3) @(negedge clk_in);
        checks++;
        if ({tri_ready_out, test_valid, pix_valid, scan_done} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=1000", {tri_ready_out, test_valid, pix_valid, scan_done});
        end
        checks++;
        if (frag_count !== 17'd0 || test_x !== 9'd0 || test_y !== 9'd0 || pix_x !== 9'd0 || pix_y !== 9'd0) begin
            failures++;
            $display("FAIL reset_values got=%0d,%0d,%0d,%0d,%0d exp=0", frag_count, test_x, test_y, pix_x, pix_y);
        end
        rst_in = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic test_example();
        int acc, q0, p0, s0;
        e_clear();
        model_add(10, 10, 13, 10, 10, 13);
        q0 = q_x.size(); p0 = p_x.size(); s0 = sd_cnt;
        tester_delay = 3;
        start_tri(10, 10, 13, 10, 10, 13, 1'b0, acc);
        wait_done(s0 + 1);
        checks++;
        if (q_x.size() - q0 != 16 || p_x.size() - p0 != 10 || frag_count !== 17'd10) begin
            failures++;
            $display("FAIL example_counts got=q%0d p%0d f%0d exp=q16 p10 f10", q_x.size() - q0, p_x.size() - p0, frag_count);
        end
        for (int i = 0; i < e_qx.size() && q0 + i < q_x.size(); i++) begin
            checks++;
            if (q_x[q0+i] != e_qx[i] || q_y[q0+i] != e_qy[i] || q_c[q0+i] != acc + 2 + i * 5) begin
                failures++;
                $display("FAIL example_query%0d got=(%0d,%0d)@%0d exp=(%0d,%0d)@%0d", i, q_x[q0+i], q_y[q0+i],
                         q_c[q0+i] - acc, e_qx[i], e_qy[i], 2 + i * 5);
            end
        end
        for (int i = 0; i < e_px.size() && p0 + i < p_x.size(); i++) begin
            checks++;
            if (p_x[p0+i] != e_px[i] || p_y[p0+i] != e_py[i]) begin
                failures++;
                $display("FAIL example_pix%0d got=(%0d,%0d) exp=(%0d,%0d)", i, p_x[p0+i], p_y[p0+i], e_px[i], e_py[i]);
            end
        end
        checks++;
        if (sd_cnt - s0 != 1 || tri_ready_out !== 1'b1) begin
            failures++;
            $display("FAIL example_done got=%0d ready=%b exp=1 ready=1", sd_cnt - s0, tri_ready_out);
        end
    endtask

    task automatic test_degenerate();
        int acc, q0, s0;
        q0 = q_x.size(); s0 = sd_cnt;
        tester_delay = 3;
        start_tri(5, 5, 5, 5, 5, 5, 1'b0, acc);
        wait_done(s0 + 1);
        checks++;
        if (q_x.size() - q0 != 1) begin
            failures++;
            $display("FAIL degen_count got=%0d exp=1", q_x.size() - q0);
        end else begin
            checks++;
            if (q_x[q0] != 5 || q_y[q0] != 5 || q_c[q0] != acc + 2) begin
                failures++;
                $display("FAIL degen_query got=(%0d,%0d)@%0d exp=(5,5)@2", q_x[q0], q_y[q0], q_c[q0] - acc);
            end
        end
        checks++;
        if (sd_cnt - s0 != 1 || frag_count !== 17'd1) begin
            failures++;
            $display("FAIL degen_done got=sd%0d f%0d exp=sd1 f1", sd_cnt - s0, frag_count);
        end
    endtask

    task automatic test_random();
        int acc, q0, p0, s0, t0;
        int c[6];
        for (int t = 0; t < 12; t++) begin
            if (t == 0) c = '{318, 0, 400, 0, 318, 2};
            else if (t == 1) c = '{330, 0, 340, 0, 330, 5};
            else begin
                int bx, by;
                bx = $urandom_range(0, 504);
                by = $urandom_range(0, 504);
                for (int k = 0; k < 3; k++) begin
                    c[2*k]   = bx + int'($urandom_range(0, 7));
                    c[2*k+1] = by + int'($urandom_range(0, 7));
                end
            end
            e_clear();
            model_add(c[0], c[1], c[2], c[3], c[4], c[5]);
            q0 = q_x.size(); p0 = p_x.size(); s0 = sd_cnt; t0 = stab_err;
            tester_delay = (t < 2) ? 1 : 0;
            start_tri(c[0], c[1], c[2], c[3], c[4], c[5], 1'b0, acc);
            wait_done(s0 + 1);
`ifdef SCREEN_CLIP_EN
            if (t < 2) begin
                checks++;
                if (q_x.size() - q0 != (t == 0 ? 6 : 0)) begin
                    failures++;
                    $display("FAIL clip%0d_count got=%0d exp=%0d", t, q_x.size() - q0, t == 0 ? 6 : 0);
                end
            end
`endif
            checks++;
            if (q_x.size() - q0 != e_qx.size() || p_x.size() - p0 != e_px.size()) begin
                failures++;
                $display("FAIL rand%0d_counts got=q%0d p%0d exp=q%0d p%0d", t, q_x.size() - q0, p_x.size() - p0,
                         e_qx.size(), e_px.size());
            end
            for (int i = 0; i < e_qx.size() && q0 + i < q_x.size(); i++) begin
                checks++;
                if (q_x[q0+i] != e_qx[i] || q_y[q0+i] != e_qy[i]) begin
                    failures++;
                    $display("FAIL rand%0d_query%0d got=(%0d,%0d) exp=(%0d,%0d)", t, i, q_x[q0+i], q_y[q0+i], e_qx[i], e_qy[i]);
                end
            end
            for (int i = 0; i < e_px.size() && p0 + i < p_x.size(); i++) begin
                checks++;
                if (p_x[p0+i] != e_px[i] || p_y[p0+i] != e_py[i]) begin
                    failures++;
                    $display("FAIL rand%0d_pix%0d got=(%0d,%0d) exp=(%0d,%0d)", t, i, p_x[p0+i], p_y[p0+i], e_px[i], e_py[i]);
                end
            end
            checks++;
            if (frag_count !== 17'(e_px.size()) || sd_cnt - s0 != 1 || stab_err != t0) begin
                failures++;
                $display("FAIL rand%0d_end got=f%0d sd%0d stab%0d exp=f%0d sd1 stab0", t, frag_count, sd_cnt - s0,
                         stab_err - t0, e_px.size());
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc, acc2, q0, s0, na_q, na_p, bad, n;
        e_clear();
        model_add(10, 10, 12, 10, 10, 12);
        na_q = e_qx.size(); na_p = e_px.size();
        model_add(40, 41, 42, 41, 41, 43);
        q0 = q_x.size(); s0 = sd_cnt; bad = 0; n = 0;
        tester_delay = 3;
        start_tri(10, 10, 12, 10, 10, 12, 1'b1, acc);
        v1[2] = 9'd40; v1[1] = 9'd41; v2[2] = 9'd42; v2[1] = 9'd41; v3[2] = 9'd41; v3[1] = 9'd43;
        forever begin
            @(negedge clk_in);
            n++;
            if (scan_done || n > 2000) break;
            if (tri_ready_out !== 1'b0) bad++;
        end
        acc2 = cyc;
        @(negedge clk_in);
        tri_valid_in = 1'b0;
        wait_done(s0 + 2);
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL b2b_ready_busy got=%0d exp=0", bad);
        end
        checks++;
        if (q_x.size() - q0 != e_qx.size()) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=%0d", q_x.size() - q0, e_qx.size());
        end else begin
            for (int i = 0; i < e_qx.size(); i++) begin
                checks++;
                if (q_x[q0+i] != e_qx[i] || q_y[q0+i] != e_qy[i]) begin
                    failures++;
                    $display("FAIL b2b_query%0d got=(%0d,%0d) exp=(%0d,%0d)", i, q_x[q0+i], q_y[q0+i], e_qx[i], e_qy[i]);
                end
            end
            checks++;
            if (q_c[q0+na_q] != acc2 + 2) begin
                failures++;
                $display("FAIL b2b_second_start got=%0d exp=%0d", q_c[q0+na_q] - acc2, 2);
            end
        end
        checks++;
        if (frag_count !== 17'(e_px.size() - na_p) || sd_cnt - s0 != 2) begin
            failures++;
            $display("FAIL b2b_end got=f%0d sd%0d exp=f%0d sd2", frag_count, sd_cnt - s0, e_px.size() - na_p);
        end
    endtask

    task automatic test_reset_mid();
        int acc, n, q0, p0, s0;
        tester_delay = 4;
        start_tri(20, 20, 22, 20, 20, 22, 1'b0, acc);
        n = 0;
        while (!test_valid && n < 50) begin
            @(negedge clk_in);
            n++;
        end
        @(negedge clk_in);
        abandon = 1'b1;
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        q0 = q_x.size(); p0 = p_x.size(); s0 = sd_cnt;
        repeat (30) @(negedge clk_in);
        abandon = 1'b0;
        checks++;
        if (q_x.size() != q0 || p_x.size() != p0 || sd_cnt != s0) begin
            failures++;
            $display("FAIL rstmid_activity got=q%0d p%0d sd%0d exp=0", q_x.size() - q0, p_x.size() - p0, sd_cnt - s0);
        end
        checks++;
        if ({tri_ready_out, test_valid, pix_valid, scan_done} !== 4'b1000 || frag_count !== 17'd0 ||
            test_x !== 9'd0 || test_y !== 9'd0 || pix_x !== 9'd0 || pix_y !== 9'd0) begin
            failures++;
            $display("FAIL rstmid_values got=%b f%0d t(%0d,%0d) p(%0d,%0d) exp=1000 f0 zeros",
                     {tri_ready_out, test_valid, pix_valid, scan_done}, frag_count, test_x, test_y, pix_x, pix_y);
        end
    endtask

    initial begin
        test_reset();
        test_example();
        test_degenerate();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_degenerate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tri_raster_scan.md
TRI_RASTER_SCAN -- requirements
Module: tri_raster_scan

Interface
REQ-001 SHALL have parameter SCREEN_W, default 320, screen width in pixels (x range 0..SCREEN_W-1).
REQ-002 SHALL have parameter SCREEN_H, default 240, screen height in pixels (y range 0..SCREEN_H-1).
REQ-003 SHALL have port clk_in  input  1  the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_in  input  1  synchronous active-high reset.
REQ-005 SHALL have ports v1, v2, v3  input  3x9 (unpacked [2:0])  triangle vertices; index 2 = x, index 1 = y, index 0 = z (z is ignored).
REQ-006 SHALL have port tri_valid_in  input  1  a triangle is presented on v1..v3.
REQ-007 SHALL have port tri_ready_out  output  1  the block accepts a triangle this cycle.
REQ-008 SHALL have ports test_x, test_y  output  9 each  pixel sent to the point-in-triangle tester.
REQ-009 SHALL have ports test_v1, test_v2, test_v3  output  3x9  latched vertices driven to the tester.
REQ-010 SHALL have port test_valid  output  1  one-cycle query strobe to the tester.
REQ-011 SHALL have ports test_in_tri and test_done  input  1 each  the tester's result and its result-valid strobe.
REQ-012 SHALL have ports pix_x, pix_y  output  9 each, and pix_valid  output  1  inside-triangle fragment stream.
REQ-013 SHALL have ports scan_done  output  1  (one-cycle end-of-triangle pulse) and frag_count  output  17  (fragments emitted for the last triangle).

Function
REQ-014 SHALL implement states IDLE, BBOX, ISSUE, WAIT, ADV.
REQ-015 IDLE: tri_ready_out=1; on tri_valid_in, SHALL latch v1..v3, clear frag_count, and go to BBOX.
REQ-016 BBOX (1 cycle): SHALL compute xmin/xmax/ymin/ymax as unsigned min/max of the three vertex x and y values, set cursor=(xmin,ymin), then go to ISSUE.
REQ-017 ISSUE: SHALL drive test_x/test_y=cursor and pulse test_valid for exactly one cycle, then go to WAIT; exactly one query SHALL be outstanding at any time.
REQ-018 WAIT: SHALL hold test_x/test_y/test_v* stable; on test_done, if test_in_tri=1 SHALL pulse pix_valid with pix_x/pix_y=cursor in the next cycle and increment frag_count (saturating at 2^17-1); then go to ADV.
REQ-019 ADV: raster order, x fastest — if x<xmax then x+1; else if y<ymax then x=xmin, y+1; else pulse scan_done and go to IDLE.
REQ-020 tri_valid_in SHALL be ignored outside IDLE (tri_ready_out=0).
REQ-021 A test_done strobe arriving outside WAIT SHALL be ignored.
REQ-022 Comparisons SHALL be inclusive, so a degenerate triangle (all vertices equal) scans exactly one pixel.
REQ-023 Latency: pixel N is queried 2 + N*(tester latency + 2) cycles after acceptance; with a 3-cycle tester, each pixel takes 5 cycles.

Reset
REQ-024 On rst_in: state=IDLE, tri_ready_out=1, test_valid=0, pix_valid=0, scan_done=0, frag_count=0, test_x=test_y=pix_x=pix_y=0.
REQ-025 Reset mid-scan SHALL abandon the triangle with no scan_done pulse; a late test_done after reset SHALL be ignored (REQ-021).

Configuration
REQ-026 With macro SCREEN_CLIP_EN defined, the bounding box SHALL be clamped to x<=SCREEN_W-1 and y<=SCREEN_H-1, and if xmin>SCREEN_W-1 or ymin>SCREEN_H-1, BBOX SHALL pulse scan_done with frag_count=0 and return to IDLE.
REQ-027 Without SCREEN_CLIP_EN, the unclamped bounding box (0..511) SHALL be scanned.

Structure
REQ-028 A shared package SHALL hold the coordinate width constant (9), the vertex component index constants (X=2, Y=1, Z=0), and the scan state enum.
REQ-029 The bounding-box min/max logic SHALL be a sub-module named tri_bbox (combinational, registered by the parent in BBOX).

Verification
REQ-030 Triangle (10,10),(13,10),(10,13) with a 3-cycle tester model -> 16 queries in raster order, 10 pix_valid pulses (x+y<=23), frag_count=10, one scan_done.
REQ-031 All vertices at (5,5) -> exactly 1 query at (5,5), scan_done after it.
REQ-032 tri_valid_in held high during a scan -> tri_ready_out=0 and the second triangle is accepted only after scan_done.
REQ-033 rst_in asserted during WAIT with test_done 2 cycles later -> no pix_valid, no scan_done, outputs at reset values.
REQ-034 SCREEN_CLIP_EN, triangle (318,0),(400,0),(318,2) -> x is scanned over 318..319 only (6 queries); triangle (330,0),(340,0),(330,5) -> zero queries, scan_done with frag_count=0.
REQ-035 Tester result delay varied 1..20 cycles -> test_x/test_y stable throughout WAIT, and the query sequence is unchanged.
